// File: rtl/cpu_boot_loader_pkg.sv
// Shared definitions for the boot loader: sequencer states, per-memory byte
// strides, output reset values and the word-index to byte-address helper.
package cpu_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_I  = 3'd1,
    ST_LOAD_D  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int unsigned IMEM_BYTES_PER_WORD = 4;
  localparam int unsigned DMEM_BYTES_PER_WORD = 8;

  localparam logic        RST_CPU_ARST_N = 1'b0;
  localparam logic        RST_WEN        = 1'b0;
  localparam logic        RST_ERR        = 1'b0;
  localparam logic [63:0] RST_ADDR       = '0;
  localparam logic [63:0] RST_WDATA      = '0;

  function automatic logic [63:0] byte_addr(input logic [31:0] idx,
                                            input int unsigned bpw);
    return 64'(idx) * 64'(bpw);
  endfunction

endpackage

// File: rtl/cpu_boot_loader_if.sv
// Valid/ready word stream feeding the boot loader.
//   s_valid : source has a word
//   s_data  : 64-bit word (low 32 bits used for instruction words)
//   s_ready : loader accepts the word this cycle
interface cpu_boot_loader_if;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/cpu_boot_loader_write_port.sv
// Registered write-port generator for the core's instruction and data
// memories. A transfer pulse produces a one-cycle strobe on the selected
// port in the following cycle, with address and data registered alongside.
//   xfer_i      : a stream word is accepted this cycle
//   dmem_sel_i  : 0 = instruction phase, 1 = data phase
//   cnt_i       : word index within the current phase
//   data_i      : accepted stream word
//   imem_*_o    : instruction memory write port (byte address, strobe, data)
//   dmem_*_o    : data memory write port (byte address, strobe, data)
module loader_write_port
  import cpu_boot_loader_pkg::*;
#(
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             xfer_i,
  input  logic             dmem_sel_i,
  input  logic [LEN_W-1:0] cnt_i,
  input  logic [63:0]      data_i,
  output logic [63:0]      imem_addr_o,
  output logic             imem_wen_o,
  output logic [31:0]      imem_wdata_o,
  output logic [63:0]      dmem_addr_o,
  output logic             dmem_wen_o,
  output logic [63:0]      dmem_wdata_o
);

  logic [63:0] iaddr_q, daddr_q, ddata_q;
  logic [31:0] idata_q;
  logic        iwen_q, dwen_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      iaddr_q <= RST_ADDR;
      idata_q <= RST_WDATA[31:0];
      iwen_q  <= RST_WEN;
      daddr_q <= RST_ADDR;
      ddata_q <= RST_WDATA;
      dwen_q  <= RST_WEN;
    end else begin
      iwen_q <= xfer_i && !dmem_sel_i;
      dwen_q <= xfer_i && dmem_sel_i;
      if (xfer_i && !dmem_sel_i) begin
        iaddr_q <= byte_addr(32'(cnt_i), IMEM_BYTES_PER_WORD);
        idata_q <= data_i[31:0];
      end
      if (xfer_i && dmem_sel_i) begin
        daddr_q <= byte_addr(32'(cnt_i), DMEM_BYTES_PER_WORD);
        ddata_q <= data_i;
      end
    end
  end

  assign imem_addr_o  = iaddr_q;
  assign imem_wen_o   = iwen_q;
  assign imem_wdata_o = idata_q;
  assign dmem_addr_o  = daddr_q;
  assign dmem_wen_o   = dwen_q;
  assign dmem_wdata_o = ddata_q;

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot sequencer upstream of the RISC-V core: loads the instruction memory,
// then the data memory, from a valid/ready stream while holding the core in
// reset, then releases reset for one cycle and enables the core for a
// programmed number of cycles.
//   clk, arst_n            : clock, asynchronous active-low reset
//   start                  : begin a sequence (accepted in IDLE/DONE only)
//   imem_len, dmem_len     : words to load per memory, sampled on start
//   run_cycles             : cycles of core enable, sampled on start
//   s (slave)              : input word stream
//   addr/wen/ren/wdata_ext : instruction memory write port
//   *_ext_2                : data memory write port
//   cpu_arst_n, enable     : core reset and enable
//   busy, done, err        : status (err = length error, sticky)
module cpu_boot_loader
  import cpu_boot_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned LEN_W      = 11
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] imem_len,
  input  logic [LEN_W-1:0] dmem_len,
  input  logic [31:0]      run_cycles,
  cpu_boot_loader_if.slave s,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  output logic             cpu_arst_n,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] IMEM_MAX = LEN_W'(IMEM_DEPTH);
  localparam logic [LEN_W-1:0] DMEM_MAX = LEN_W'(DMEM_DEPTH);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, ilen_q, ilen_d, dlen_q, dlen_d;
  logic [31:0]      run_q, run_d, rcnt_q, rcnt_d;
  logic             err_q, err_d, cpu_arst_n_q, cpu_arst_n_d;
  logic             xfer;

  assign s.s_ready = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D);
  assign xfer      = s.s_valid && s.s_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ilen_d       = ilen_q;
    dlen_d       = dlen_q;
    run_d        = run_q;
    rcnt_d       = rcnt_q;
    err_d        = err_q;
    cpu_arst_n_d = cpu_arst_n_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ilen_d       = imem_len;
          dlen_d       = dmem_len;
          run_d        = run_cycles;
          err_d        = 1'b0;
          cnt_d        = '0;
          cpu_arst_n_d = 1'b0;
          if (imem_len > IMEM_MAX || dmem_len > DMEM_MAX) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (imem_len != '0) begin
            state_d = ST_LOAD_I;
          end else if (dmem_len != '0) begin
            state_d = ST_LOAD_D;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_LOAD_I: begin
        if (xfer) begin
          if (cnt_q == ilen_q - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = (dlen_q != '0) ? ST_LOAD_D : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      ST_LOAD_D: begin
        if (xfer) begin
          if (cnt_q == dlen_q - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        rcnt_d  = run_q;
        state_d = (run_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (rcnt_q == 32'd1) state_d = ST_DONE;
        else                 rcnt_d  = rcnt_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Core reset is held (not recomputed per state) so a length-error start
    // leaves it asserted while DONE after a good run keeps it released.
    if (state_d == ST_RELEASE) cpu_arst_n_d = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ilen_q       <= '0;
      dlen_q       <= '0;
      run_q        <= '0;
      rcnt_q       <= '0;
      err_q        <= RST_ERR;
      cpu_arst_n_q <= RST_CPU_ARST_N;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ilen_q       <= ilen_d;
      dlen_q       <= dlen_d;
      run_q        <= run_d;
      rcnt_q       <= rcnt_d;
      err_q        <= err_d;
      cpu_arst_n_q <= cpu_arst_n_d;
    end
  end

  loader_write_port #(.LEN_W(LEN_W)) u_wport (
    .clk         (clk),
    .arst_n      (arst_n),
    .xfer_i      (xfer),
    .dmem_sel_i  (state_q == ST_LOAD_D),
    .cnt_i       (cnt_q),
    .data_i      (s.s_data),
    .imem_addr_o (addr_ext),
    .imem_wen_o  (wen_ext),
    .imem_wdata_o(wdata_ext),
    .dmem_addr_o (addr_ext_2),
    .dmem_wen_o  (wen_ext_2),
    .dmem_wdata_o(wdata_ext_2)
  );

  assign ren_ext    = 1'b0;
  assign ren_ext_2  = 1'b0;
  assign cpu_arst_n = cpu_arst_n_q;
  assign enable     = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule
